// File: rtl/chunk_mem_arbiter_pkg.sv
// Shared constants and types for the chunk memory read arbiter.
// The optional burst lock is enabled with CHUNK_MEM_ARB_BURST_LOCK_EN.
package chunk_mem_arbiter_pkg;

    localparam int MEM_WORD_BYTES          = 4;
    localparam int BYTES_IN_CHUNK          = 64;
    localparam int WORDS_IN_CHUNK          = BYTES_IN_CHUNK / MEM_WORD_BYTES;
    localparam int MEM_ARB_MAX_OUTSTANDING = 8;
    localparam int MEM_ADDR_W              = 32;
    localparam int MEM_DATA_W              = 32;

    typedef enum logic [0:0] {
        LOCK_IDLE = 1'b0,
        LOCK_HELD = 1'b1
    } lock_state_e;

endpackage

// File: rtl/chunk_mem_arbiter_if.sv
// Requester-side and memory-side handshake bundle of the chunk memory arbiter.
// slave is the arbiter view, master is the view of whatever drives the arbiter.
interface chunk_mem_arbiter_if
    import chunk_mem_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]                 req_addr_vld;
    logic [NUM_REQ-1:0][MEM_ADDR_W-1:0] req_addr;
    logic [NUM_REQ-1:0]                 req_addr_rdy;
    logic [NUM_REQ-1:0]                 req_data_vld;
    logic [MEM_DATA_W-1:0]              req_data;
    logic                               mem_addr_vld;
    logic [MEM_ADDR_W-1:0]              mem_addr;
    logic                               mem_addr_rdy;
    logic                               mem_data_vld;
    logic [MEM_DATA_W-1:0]              mem_data;
    logic                               busy;
    logic                               err_orphan;

    modport slave (
        input  req_addr_vld, req_addr, mem_addr_rdy, mem_data_vld, mem_data,
        output req_addr_rdy, req_data_vld, req_data, mem_addr_vld, mem_addr,
               busy, err_orphan
    );

    modport master (
        output req_addr_vld, req_addr, mem_addr_rdy, mem_data_vld, mem_data,
        input  req_addr_rdy, req_data_vld, req_data, mem_addr_vld, mem_addr,
               busy, err_orphan
    );
endinterface

// File: rtl/chunk_mem_arb_tag_fifo.sv
// In-order FIFO of requester tags for reads that are issued but not yet returned.
// Push while full and pop while empty are ignored.
module chunk_mem_arb_tag_fifo #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign empty     = (count_r == {CNT_W{1'b0}});
    assign full      = (count_r == CNT_W'(DEPTH));
    assign count     = count_r;
    assign head      = mem_r[rd_ptr_r];
    assign push_ok_s = push & ~full;
    assign pop_ok_s  = pop & ~empty;

    // tag storage; contents are only meaningful below count
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // pointers and occupancy; DEPTH is a power of two so pointers wrap naturally
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end
endmodule

// File: rtl/chunk_mem_arbiter.sv
// Round-robin arbiter sharing one memory read port among NUM_REQ chunk-fill engines.
// Define CHUNK_MEM_ARB_BURST_LOCK_EN to keep the grant on one requester for a whole chunk.
module chunk_mem_arbiter
    import chunk_mem_arbiter_pkg::*;
#(
    parameter int NUM_REQ         = 4,
    parameter int MAX_OUTSTANDING = MEM_ARB_MAX_OUTSTANDING
) (
    input  logic                clk,
    input  logic                rst,
    chunk_mem_arbiter_if.slave  bus
);
    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;

    logic [IDX_W-1:0]   rr_ptr_r;
    logic [IDX_W-1:0]   rr_ptr_nxt_s;
    logic [NUM_REQ-1:0] eligible_s;
    logic [IDX_W-1:0]   start_s;
    logic [IDX_W:0]     pick_s;
    logic [IDX_W-1:0]   win_s;
    logic               can_issue_s;
    logic               accept_s;
    logic               pop_s;
    logic               orphan_s;
    logic [IDX_W-1:0]   head_s;
    logic               empty_s;
    logic               full_s;
    logic [CNT_W-1:0]   count_s;
    logic [CNT_W-1:0]   count_nxt_s;
    logic               busy_r;
    logic               err_orphan_r;

    function automatic logic [IDX_W-1:0] idx_inc(input logic [IDX_W-1:0] idx);
        logic [IDX_W-1:0] res;
        if (int'(idx) == NUM_REQ - 1) begin
            res = {IDX_W{1'b0}};
        end else begin
            res = idx + IDX_W'(1);
        end
        return res;
    endfunction

    // {found, index} of the first set bit at or after ptr, wrapping
    function automatic logic [IDX_W:0] rr_pick(input logic [NUM_REQ-1:0] vld,
                                               input logic [IDX_W-1:0]   ptr);
        logic [IDX_W:0] res;
        int             j;
        res = {(IDX_W+1){1'b0}};
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            j = int'(ptr) + i;
            if (j >= NUM_REQ) begin
                j = j - NUM_REQ;
            end
            if (vld[j]) begin
                res = {1'b1, IDX_W'(j)};
            end
        end
        return res;
    endfunction

    assign pick_s      = rr_pick(eligible_s, start_s);
    assign win_s       = pick_s[IDX_W-1:0];
    assign can_issue_s = (count_s < CNT_W'(MAX_OUTSTANDING));
    // rst gating keeps every strobe low for the whole reset assertion
    assign bus.mem_addr_vld = rst & pick_s[IDX_W] & can_issue_s;
    assign bus.mem_addr     = bus.req_addr[win_s];
    assign accept_s         = bus.mem_addr_vld & bus.mem_addr_rdy;
    assign bus.req_addr_rdy = {{(NUM_REQ-1){1'b0}}, accept_s} << win_s;
    assign pop_s            = rst & bus.mem_data_vld & ~empty_s;
    assign orphan_s         = rst & bus.mem_data_vld & empty_s;
    assign bus.req_data_vld = {{(NUM_REQ-1){1'b0}}, pop_s} << head_s;
    assign bus.req_data     = bus.mem_data;
    assign count_nxt_s      = count_s + CNT_W'(accept_s) - CNT_W'(pop_s);
    assign bus.busy         = busy_r;
    assign bus.err_orphan   = err_orphan_r;

    chunk_mem_arb_tag_fifo #(
        .WIDTH (IDX_W),
        .DEPTH (MAX_OUTSTANDING)
    ) u_tag_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (accept_s),
        .push_data (win_s),
        .pop       (pop_s),
        .head      (head_s),
        .empty     (empty_s),
        .full      (full_s),
        .count     (count_s)
    );

`ifdef CHUNK_MEM_ARB_BURST_LOCK_EN
    lock_state_e      lock_state_r;
    lock_state_e      lock_state_nxt_s;
    logic [IDX_W-1:0] lock_idx_r;
    logic [IDX_W-1:0] lock_idx_nxt_s;
    logic [3:0]       beat_r;
    logic [3:0]       beat_nxt_s;

    // lock FSM: a dropped lock owner releases in the same cycle so the next requester is not delayed
    always_comb begin
        lock_state_nxt_s = lock_state_r;
        lock_idx_nxt_s   = lock_idx_r;
        beat_nxt_s       = beat_r;
        rr_ptr_nxt_s     = rr_ptr_r;
        eligible_s       = bus.req_addr_vld;
        start_s          = rr_ptr_r;
        case (lock_state_r)
            LOCK_IDLE: begin
                if (accept_s) begin
                    lock_state_nxt_s = LOCK_HELD;
                    lock_idx_nxt_s   = win_s;
                    beat_nxt_s       = 4'd1;
                end else begin
                    lock_state_nxt_s = LOCK_IDLE;
                end
            end
            LOCK_HELD: begin
                if (!bus.req_addr_vld[lock_idx_r]) begin
                    start_s      = idx_inc(lock_idx_r);
                    rr_ptr_nxt_s = idx_inc(lock_idx_r);
                    if (accept_s) begin
                        lock_idx_nxt_s = win_s;
                        beat_nxt_s     = 4'd1;
                    end else begin
                        lock_state_nxt_s = LOCK_IDLE;
                        beat_nxt_s       = 4'd0;
                    end
                end else begin
                    eligible_s = {{(NUM_REQ-1){1'b0}}, 1'b1} << lock_idx_r;
                    if (accept_s && (beat_r == 4'(WORDS_IN_CHUNK - 1))) begin
                        lock_state_nxt_s = LOCK_IDLE;
                        beat_nxt_s       = 4'd0;
                        rr_ptr_nxt_s     = idx_inc(lock_idx_r);
                    end else if (accept_s) begin
                        beat_nxt_s = beat_r + 4'd1;
                    end else begin
                        beat_nxt_s = beat_r;
                    end
                end
            end
            default: begin
                lock_state_nxt_s = LOCK_IDLE;
                beat_nxt_s       = 4'd0;
            end
        endcase
    end

    // lock state registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lock_state_r <= LOCK_IDLE;
            lock_idx_r   <= {IDX_W{1'b0}};
            beat_r       <= 4'd0;
        end else begin
            lock_state_r <= lock_state_nxt_s;
            lock_idx_r   <= lock_idx_nxt_s;
            beat_r       <= beat_nxt_s;
        end
    end
`else
    // per-beat round robin: the pointer moves past each accepted winner
    always_comb begin
        eligible_s = bus.req_addr_vld;
        start_s    = rr_ptr_r;
        if (accept_s) begin
            rr_ptr_nxt_s = idx_inc(win_s);
        end else begin
            rr_ptr_nxt_s = rr_ptr_r;
        end
    end
`endif

    // round-robin pointer, busy flag and sticky orphan flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr_r     <= {IDX_W{1'b0}};
            busy_r       <= 1'b0;
            err_orphan_r <= 1'b0;
        end else begin
            rr_ptr_r     <= rr_ptr_nxt_s;
            busy_r       <= (count_nxt_s != {CNT_W{1'b0}});
            err_orphan_r <= err_orphan_r | orphan_s;
        end
    end
endmodule

// File: doc/chunk_mem_arbiter.md
# chunk_mem_arbiter

Round-robin read arbiter that lets `NUM_REQ` chunk-fill engines share one word-wide memory read port. Each accepted address is tagged with its requester index in an in-order tag FIFO, and the returning data beat is steered back to that requester. It sits between the per-lane chunk processors and the single memory interface of the SHA-256 engine.

## Interface
- `NUM_REQ`, 4: number of requester ports; must be at least 2.
- `MAX_OUTSTANDING`, 8: maximum issued but not yet returned reads; power of 2.
- `IDX_W`, $clog2(NUM_REQ): width of a requester index (derived, not overridden).

Ports:
- `clk`  input  1  clock; all logic is on the rising edge.
- `rst`  input  1  reset, asynchronous and active-low.
- `req_addr_vld`  input  NUM_REQ  per-requester address valid.
- `req_addr`  input  NUM_REQ×32  per-requester byte address; must be word aligned.
- `req_addr_rdy`  output  NUM_REQ  one-hot grant; the address is accepted when vld and rdy are both high.
- `req_data_vld`  output  NUM_REQ  one-hot return strobe.
- `req_data`  output  32  return data, broadcast to all requesters.
- `mem_addr_vld`  output  1  memory address valid.
- `mem_addr`  output  32  memory address.
- `mem_addr_rdy`  input  1  memory accepts the address.
- `mem_data_vld`  input  1  return beat; returns arrive strictly in issue order.
- `mem_data`  input  32  return data.
- `busy`  output  1  high while outstanding count ≠ 0.
- `err_orphan`  output  1  sticky: a return beat arrived with no outstanding read.

## Operation
- **Issue.**
  - `can_issue = (outstanding < MAX_OUTSTANDING)`.
  - Arbiter: round-robin starting at `rr_ptr`. The winner `w` is the first set bit of `req_addr_vld` at or after `rr_ptr`, wrapping.
  - `mem_addr_vld = |req_addr_vld & can_issue`. `mem_addr = req_addr[w]`.
  - `req_addr_rdy[w] = mem_addr_vld & mem_addr_rdy`. All other bits are 0.
- **Accept** (`mem_addr_vld & mem_addr_rdy`):
  - push `w` into the tag FIFO;
  - `rr_ptr <= (w+1) mod NUM_REQ`.
  - `rr_ptr` does not move without an accept.
- **Return** (`mem_data_vld`):
  - pop the tag FIFO head `t`;
  - `req_data_vld = 1<<t`, combinational from `mem_data_vld`;
  - `req_data = mem_data`.
- **Outstanding counter.**
  - Width is $clog2(MAX_OUTSTANDING)+1.
  - +1 on accept, −1 on return; unchanged when both occur in the same cycle.
  - It equals the FIFO occupancy.
- **Orphan return** (`mem_data_vld` with FIFO empty):
  - no pop;
  - `req_data_vld = 0`;
  - `err_orphan` sets and stays set until reset.
- **Requester rule.** A requester must hold `req_addr_vld` and `req_addr` stable until granted. The arbiter does not check this.

## Timing
- The address path is combinational, requester to memory, with zero cycles of latency.
- The return path is combinational, `mem_data_vld` to `req_data_vld`.
- Sustained throughput is 1 accept per cycle while `can_issue` and `mem_addr_rdy` are high.
- **FIFO full** (outstanding == MAX_OUTSTANDING): `mem_addr_vld = 0` and all rdy bits are 0.
  - A return in that same cycle does not free a slot until the next cycle. The full check uses the registered count.
- **FIFO empty with a same-cycle accept and return:** the return is an orphan. Accepted tags are not bypassed.
- **Reset** (`rst` low, any time, including mid-burst):
  - `outstanding = 0`, FIFO pointers 0, `rr_ptr = 0`, `err_orphan = 0`, `busy = 0`;
  - all rdy/vld outputs are 0 while `rst` is low;
  - in-flight returns after reset release count as orphans.

## Configuration
- **`CHUNK_MEM_ARB_BURST_LOCK_EN` defined:**
  - after an accept for requester `w`, the grant locks to `w`. A 4-bit beat counter starts at 1.
  - While locked, only `w` is eligible. `rr_ptr` does not advance.
  - The lock releases when any of these occur:
    - the counter reaches `sha256_pkg::WORDS_IN_CHUNK` (16) accepts;
    - `req_addr_vld[w]` drops;
    - reset.
  - On release, `rr_ptr <= (w+1) mod NUM_REQ` and the counter clears.
  - Result: a full 64-byte chunk fill issues contiguously.
- **Undefined:** the block does per-beat round-robin with no lock state.

## Structure
- Into `sha256_pkg`:
  - `MEM_WORD_BYTES` (existing);
  - `WORDS_IN_CHUNK = BYTES_IN_CHUNK/MEM_WORD_BYTES`;
  - `MEM_ARB_MAX_OUTSTANDING` default.
- One sub-module, `chunk_mem_arb_tag_fifo`:
  - synchronous FIFO of `IDX_W`-wide entries with depth `MAX_OUTSTANDING`;
  - ports: push/pop/head/empty/full/count;
  - same asynchronous active-low reset.
- The round-robin pick stays inline as a combinational function.

## Test plan
- **Single requester.** Requester 2 drives vld with addrs 0x100, 0x104, 0x108, `mem_addr_rdy = 1`, memory latency 3.
  - Expect 3 accepts in consecutive cycles.
  - Expect `req_data_vld = 4'b0100` on each return, with data in order.
- **All 4 requesting, macro off.** Expect the grant order 0,1,2,3,0,1…, one per cycle. The return strobes follow the same order.
- **Backpressure and full.** `mem_addr_rdy = 1`, memory never returns.
  - Expect exactly 8 accepts, then `mem_addr_vld = 0`.
  - The first return lets one more accept happen on the following cycle, not the same one.
- **Simultaneous accept and return at count 5.** Count stays 5. The FIFO head advances and the tail advances.
- **Orphan.** `mem_data_vld` pulsed with nothing outstanding. Expect `err_orphan = 1`, all `req_data_vld = 0`, and the flag held until `rst` low.
- **Macro on.** Requesters 0 and 1 both request continuously.
  - Expect 16 grants to 0, then 16 to 1.
  - Dropping `req_addr_vld[0]` after 5 beats hands the grant to 1 on the next cycle.
  - Asserting `rst` mid-burst clears the count, FIFO and lock.
